// File: rtl/cpu_dbg_pkg.sv
// Shared types and default sizes for the CPU debug/run controller.
// Holds the 3-bit controller state encoding used by cpu_debug_ctrl.
package cpu_dbg_pkg;

    localparam int DBG_DATA_W       = 8;
    localparam int DBG_RADDR_W      = 3;
    localparam int DBG_PC_W         = 5;
    localparam int DBG_STEP_TIMEOUT = 64;

    typedef enum logic [2:0] {
        S_RUN       = 3'd0,
        S_HALT_PEND = 3'd1,
        S_HALTED    = 3'd2,
        S_STEP      = 3'd3,
        S_REG_RD    = 3'd4,
        S_REG_CAP   = 3'd5,
        S_REG_WR    = 3'd6
    } dbg_state_e;

endpackage

// File: rtl/cpu_debug_ctrl_step_timer.sv
// Single-step watchdog counter: cleared when a step starts, counts while
// stepping, and flags expiry on the STEP_TIMEOUT-th stepping cycle.
module dbg_step_timer
    import cpu_dbg_pkg::*;
#(
    parameter int STEP_TIMEOUT = DBG_STEP_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int CW = $clog2(STEP_TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(STEP_TIMEOUT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/cpu_debug_ctrl.sv
// Debug/run controller: halt, resume, single-step and halted RF access.
// Optional breakpoint comparator enabled by macro CPU_DBG_BREAKPOINT_EN.
module cpu_debug_ctrl
    import cpu_dbg_pkg::*;
#(
    parameter int DATA_W        = DBG_DATA_W,
    parameter int RADDR_W       = DBG_RADDR_W,
    parameter int PC_W          = DBG_PC_W,
    parameter int STEP_TIMEOUT  = DBG_STEP_TIMEOUT,
    parameter bit HALT_ON_RESET = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PC_W-1:0]    pc_value,
    input  logic               fsm_pc_enable,
    input  logic               fsm_rom_enable,
    input  logic               fsm_we,
    input  logic [RADDR_W-1:0] fsm_w_address,
    input  logic [DATA_W-1:0]  fsm_w_data,
    input  logic [RADDR_W-1:0] fsm_r_address1,
    input  logic [DATA_W-1:0]  rf_r_data1,
    output logic               core_en,
    output logic               pc_enable_out,
    output logic               rom_enable_out,
    output logic               rf_we,
    output logic [RADDR_W-1:0] rf_w_address,
    output logic [DATA_W-1:0]  rf_w_data,
    output logic [RADDR_W-1:0] rf_r_address1,
    input  logic               dbg_halt_req,
    input  logic               dbg_resume_req,
    input  logic               dbg_step_req,
    input  logic               dbg_reg_valid,
    input  logic               dbg_reg_write,
    input  logic [RADDR_W-1:0] dbg_reg_addr,
    input  logic [DATA_W-1:0]  dbg_reg_wdata,
    output logic               dbg_reg_ready,
    output logic               dbg_ack,
    output logic [DATA_W-1:0]  dbg_rdata,
    output logic               halted,
`ifdef CPU_DBG_BREAKPOINT_EN
    input  logic               bp_valid,
    input  logic [PC_W-1:0]    bp_pc,
    output logic               bp_hit,
`endif
    output logic               step_done,
    output logic               step_timeout
);

    localparam dbg_state_e RST_STATE = HALT_ON_RESET ? S_HALTED : S_RUN;

    dbg_state_e         state_q, state_d;
    logic [RADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               ack_q, ack_d;
    logic               done_q, done_d;
    logic               tmo_q, tmo_d;
    logic               tmr_clr, tmr_expire;
    logic               boundary;
    logic               bp_fire;

    assign core_en = (state_q == S_RUN) || (state_q == S_HALT_PEND)
                  || (state_q == S_STEP);
    assign boundary       = fsm_pc_enable & core_en;
    assign pc_enable_out  = boundary;
    assign rom_enable_out = fsm_rom_enable & core_en;

`ifdef CPU_DBG_BREAKPOINT_EN
    // skip_q masks the breakpoint for the first instruction after leaving
    // HALTED, so resuming at the breakpoint PC does not re-halt at once.
    logic skip_q, skip_d;

    assign bp_fire = bp_valid && (pc_value == bp_pc) && !skip_q;
    assign bp_hit  = (state_q == S_RUN) && bp_fire;

    always_comb begin
        skip_d = skip_q;
        if (state_q == S_HALTED && !dbg_reg_valid
            && (dbg_step_req || dbg_resume_req)) begin
            skip_d = 1'b1;
        end else if (state_q == S_RUN && boundary) begin
            skip_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            skip_q <= 1'b0;
        end else begin
            skip_q <= skip_d;
        end
    end
`else
    logic pc_unused;

    assign bp_fire   = 1'b0;
    assign pc_unused = ^pc_value;
`endif

    dbg_step_timer #(
        .STEP_TIMEOUT(STEP_TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (tmr_clr),
        .en_i    (state_q == S_STEP),
        .expire_o(tmr_expire)
    );

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        rdata_d       = rdata_q;
        ack_d         = 1'b0;
        done_d        = 1'b0;
        tmo_d         = tmo_q;
        tmr_clr       = 1'b0;
        dbg_reg_ready = 1'b0;
        unique case (state_q)
            S_RUN: begin
                if (dbg_halt_req || bp_fire) begin
                    state_d = S_HALT_PEND;
                end
            end
            S_HALT_PEND: begin
                if (boundary) begin
                    state_d = S_HALTED;
                end
            end
            S_HALTED: begin
                if (dbg_reg_valid) begin
                    dbg_reg_ready = 1'b1;
                    addr_d        = dbg_reg_addr;
                    wdata_d       = dbg_reg_wdata;
                    state_d       = dbg_reg_write ? S_REG_WR : S_REG_RD;
                end else if (dbg_step_req) begin
                    tmo_d   = 1'b0;
                    tmr_clr = 1'b1;
                    state_d = S_STEP;
                end else if (dbg_resume_req) begin
                    tmo_d   = 1'b0;
                    state_d = S_RUN;
                end
            end
            S_STEP: begin
                // A boundary in the expiry cycle still counts as a good step.
                if (boundary) begin
                    done_d  = 1'b1;
                    state_d = S_HALTED;
                end else if (tmr_expire) begin
                    tmo_d   = 1'b1;
                    state_d = S_HALTED;
                end
            end
            S_REG_RD: begin
                state_d = S_REG_CAP;
            end
            S_REG_CAP: begin
                rdata_d = rf_r_data1;
                state_d = S_HALTED;
            end
            S_REG_WR: begin
                ack_d   = 1'b1;
                state_d = S_HALTED;
            end
            default: begin
                state_d = RST_STATE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RST_STATE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            done_q  <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
            tmo_q   <= tmo_d;
        end
    end

    assign rf_we         = (state_q == S_REG_WR) | (fsm_we & core_en);
    assign rf_w_address  = (state_q == S_REG_WR) ? addr_q : fsm_w_address;
    assign rf_w_data     = (state_q == S_REG_WR) ? wdata_q : fsm_w_data;
    assign rf_r_address1 = (state_q == S_REG_RD || state_q == S_REG_CAP)
                         ? addr_q : fsm_r_address1;

    // Read data is shown live during REG_CAP and held from rdata_q after.
    assign dbg_ack   = ack_q | (state_q == S_REG_CAP);
    assign dbg_rdata = (state_q == S_REG_CAP) ? rf_r_data1 : rdata_q;

    assign halted       = (state_q == S_HALTED);
    assign step_done    = done_q;
    assign step_timeout = tmo_q;

endmodule

// File: doc/cpu_debug_ctrl.md
Name: cpu_debug_ctrl

Overview:
Debug/run controller that sequences the CPU datapath (pc, rom, fsm_control, register_file).
- Halts, resumes and single-steps the core at instruction boundaries by driving a core enable and gating PC, ROM and register-file writes.
- While halted, a host-side req/ack port can read and write the register file through a muxed port.
- Sits between fsm_control and register_file inside cpu_subsystem.

Parameters:
DATA_W, 8, register data width
RADDR_W, 3, register address width
PC_W, 5, program counter width
STEP_TIMEOUT, 64, max cycles a single step may take before abort (>=2)
HALT_ON_RESET, 0, 1 = leave reset in HALTED instead of RUN

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
pc_value  in  PC_W  current PC
fsm_pc_enable  in  1  PC advance request from fsm_control
fsm_rom_enable  in  1  ROM enable from fsm_control
fsm_we  in  1  FSM register write enable
fsm_w_address  in  RADDR_W  FSM write address
fsm_w_data  in  DATA_W  FSM write data
fsm_r_address1  in  RADDR_W  FSM read address 1
rf_r_data1  in  DATA_W  register file read data 1
core_en  out  1  enable for fsm_control/pc sequencing
pc_enable_out  out  1  gated PC enable
rom_enable_out  out  1  gated ROM enable
rf_we  out  1  muxed write enable
rf_w_address  out  RADDR_W  muxed write address
rf_w_data  out  DATA_W  muxed write data
rf_r_address1  out  RADDR_W  muxed read address 1
dbg_halt_req  in  1  halt request (level)
dbg_resume_req  in  1  resume request (level)
dbg_step_req  in  1  single-step request (level)
dbg_reg_valid  in  1  register access request
dbg_reg_write  in  1  1 = write, 0 = read
dbg_reg_addr  in  RADDR_W  register index
dbg_reg_wdata  in  DATA_W  write data
dbg_reg_ready  out  1  access accepted this cycle
dbg_ack  out  1  one-cycle completion pulse
dbg_rdata  out  DATA_W  read data, valid while dbg_ack and last op was read; held otherwise
halted  out  1  core is in HALTED
step_done  out  1  one-cycle pulse when a step completes
step_timeout  out  1  sticky: last step aborted

Behaviour:
States: RUN, HALT_PEND, HALTED, STEP, REG_RD, REG_CAP, REG_WR.
- Reset (rst=0, async): state RUN, or HALTED if HALT_ON_RESET=1.
  - halted = (state==HALTED).
  - dbg_reg_ready, dbg_ack, step_done, step_timeout = 0.
  - dbg_rdata = 0; step counter = 0.
- Instruction boundary (boundary) = fsm_pc_enable & core_en.
- core_en = 1 in RUN, HALT_PEND, STEP; 0 elsewhere.
- pc_enable_out = fsm_pc_enable & core_en; rom_enable_out = fsm_rom_enable & core_en.
- RF mux: in REG_WR, rf_we=1 and the address/data come from the latched debug values. In REG_RD/REG_CAP, rf_r_address1 = latched address. Otherwise the FSM signals pass through, with rf_we = fsm_we & core_en.
- RUN: dbg_halt_req → HALT_PEND. dbg_resume_req and dbg_step_req are ignored.
- HALT_PEND: on boundary → HALTED. The boundary instruction completes and its PC increment is allowed. A mid-instruction halt never occurs.
- HALTED: one request is taken per cycle, priority reg access > step > resume.
  - dbg_reg_valid: dbg_reg_ready=1 combinationally; latch addr/wdata; go to REG_WR (write) or REG_RD (read).
  - dbg_step_req: clear step_timeout and the counter; go to STEP.
  - dbg_resume_req: clear step_timeout; go to RUN.
  - dbg_halt_req is ignored.
- REG_WR: rf_we=1 for exactly 1 cycle; dbg_ack=1 next cycle; → HALTED. Write latency is 2 cycles from accept.
- REG_RD: drive the address → REG_CAP. REG_CAP: capture rf_r_data1 into dbg_rdata, pulse dbg_ack, → HALTED. Read data appears with ack 2 cycles after accept.
- STEP: the counter increments each cycle.
  - On boundary: step_done=1 for 1 cycle → HALTED.
  - If the counter reaches STEP_TIMEOUT-1 without a boundary: step_timeout=1, → HALTED.
  - If boundary and timeout occur in the same cycle, the boundary wins (no timeout).
- Simultaneous halt+resume in RUN: halt wins. Requests arriving while in the REG_*/STEP states are ignored until HALTED is re-entered (levels are re-sampled there).
- Reset mid-access or mid-step: abort, no ack/step_done, return to reset state.

Optional Feature:
CPU_DBG_BREAKPOINT_EN
- With the macro: extra ports bp_valid in 1 and bp_pc in PC_W, plus a bp_hit out 1 one-cycle pulse.
  - In RUN, when bp_valid & (pc_value==bp_pc): go to HALT_PEND and pulse bp_hit.
  - A breakpoint does not re-trigger on the first instruction after resume/step from the same PC.
- Without the macro: no extra ports or logic; behaviour is exactly as above.

Decomposition:
- Package cpu_dbg_pkg holds the state enum encoding (3 bits), default widths, and the STEP_TIMEOUT default.
- Sub-module dbg_step_timer: counter with clear/enable/expire, parameterised by STEP_TIMEOUT.
- The mux and FSM stay in the top module.

Test Plan:
- Halt: RUN, assert halt, fsm_pc_enable pulses 3 cycles later → halted=1 the cycle after the pulse; pc_enable_out=0 and rf_we=0 while fsm_we=1.
- Reg write/read: while halted, write addr 5 data 0xA5 → rf_we for 1 cycle at addr 5, ack 2 cycles after accept. Then read addr 5 with rf_r_data1=0xA5 → dbg_rdata=0xA5 with ack.
- Step: halted, step_req with boundary 4 cycles later → step_done pulse, back to HALTED, PC advanced exactly once.
- Timeout: STEP_TIMEOUT=8, step with no boundary → step_timeout=1 after 8 cycles, halted=1; resume clears it.
- Priority/reset: halted with reg_valid, step_req and resume_req in the same cycle → reg access first. Assert rst=0 during REG_RD → no ack, state RUN (HALTED with HALT_ON_RESET=1), all outputs at reset values.
